// File: rtl/sram_like_arbiter_if.sv
// sram-like bus bundle shared by the CPU masters and the memory slave.
// master drives the request, slave answers with addr_ok/data_ok/rdata.
interface sram_like_arbiter_if;
  logic        en;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output en, wr, size, wen, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  en, wr, size, wen, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Merges inst and data sram-like masters onto one slave port.
// Owner-ID FIFO routes in-order responses back to the issuer.
module sram_like_arbiter #(
  parameter int MAX_OUTST = 4,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram_like_arbiter_if.slave   inst,
  sram_like_arbiter_if.slave   data,
  sram_like_arbiter_if.master  mem,
  output logic                 arb_err
);

  localparam int PW = $clog2(MAX_OUTST);

  logic [PW:0]          r_wr_ptr;
  logic [PW:0]          r_rd_ptr;
  logic [MAX_OUTST-1:0] r_owner;
  logic                 r_lock_vld;
  logic                 r_lock_id;
  logic                 r_arb_err;

  logic w_gnt;
  logic w_gnt_en;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

  // grant: 1 = data master, 0 = inst master
  always_comb begin
    w_gnt = 1'b0;
    if (r_lock_vld)
      w_gnt = r_lock_id;
    else if (DATA_PRIO)
      w_gnt = data.en ? 1'b1 : 1'b0;
    else
      w_gnt = inst.en ? 1'b0 : 1'b1;
  end

  assign w_gnt_en = w_gnt ? data.en : inst.en;

  assign mem.en    = w_gnt_en & ~w_full & resetn;
  assign mem.wr    = w_gnt ? data.wr    : inst.wr;
  assign mem.size  = w_gnt ? data.size  : inst.size;
  assign mem.wen   = w_gnt ? data.wen   : inst.wen;
  assign mem.addr  = w_gnt ? data.addr  : inst.addr;
  assign mem.wdata = w_gnt ? data.wdata : inst.wdata;

  assign w_push = mem.en & mem.addr_ok;
  assign w_pop  = mem.data_ok & ~w_empty;
  assign w_head = r_owner[r_rd_ptr[PW-1:0]];

  assign inst.addr_ok = w_push & ~w_gnt;
  assign data.addr_ok = w_push &  w_gnt;
  assign inst.data_ok = w_pop  & ~w_head;
  assign data.data_ok = w_pop  &  w_head;
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  assign arb_err = r_arb_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_owner  <= '0;
    end else begin
      if (w_push) begin
        r_owner[r_wr_ptr[PW-1:0]] <= w_gnt;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // hold the stalled master on the bus until the slave accepts it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock_vld <= 1'b0;
      r_lock_id  <= 1'b0;
    end else begin
      r_lock_vld <= mem.en & ~mem.addr_ok;
      if (mem.en & ~mem.addr_ok)
        r_lock_id <= w_gnt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_arb_err <= 1'b0;
    else if (mem.data_ok & w_empty)
      r_arb_err <= 1'b1;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scenario bench for sram_like_arbiter with an owner/rdata scoreboard.
// Expected responses are queued at accept and popped at data_ok.
module tb_sram_like_arbiter;

  typedef struct {
    bit          owner;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic resetn;
  logic arb_err;
  int   n_chk;
  int   n_pass;
  exp_t sb[$];

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if mem_if ();

  sram_like_arbiter #(
    .MAX_OUTST(4),
    .DATA_PRIO(1'b1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .inst   (inst_if),
    .data   (data_if),
    .mem    (mem_if),
    .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_if.en = 0; inst_if.wr = 0;
    inst_if.size = 2'd2; inst_if.wen = 0;
    inst_if.addr = 0; inst_if.wdata = 0;
    data_if.en = 0; data_if.wr = 0;
    data_if.size = 2'd2; data_if.wen = 0;
    data_if.addr = 0; data_if.wdata = 0;
    mem_if.addr_ok = 0; mem_if.data_ok = 0;
    mem_if.rdata = 0;
  endtask

  task automatic respond();
    exp_t e;
    mem_if.data_ok = 1;
    mem_if.rdata = (sb.size() != 0) ?
      sb[0].rdata : 32'hdead0000;
    @(negedge clk);
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL resp_sb_empty no expected entry");
    end else begin
      e = sb.pop_front();
      if ({inst_if.data_ok, data_if.data_ok} !==
          (e.owner ? 2'b01 : 2'b10))
        $display("FAIL resp_route got i=%b d=%b exp owner=%0d",
                 inst_if.data_ok, data_if.data_ok, e.owner);
      else if ((e.owner ? data_if.rdata : inst_if.rdata)
               !== e.rdata)
        $display("FAIL resp_rdata got %h exp %h",
                 e.owner ? data_if.rdata : inst_if.rdata,
                 e.rdata);
      else
        n_pass++;
    end
    cycle();
    mem_if.data_ok = 0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 0;
    inst_if.en = 1;
    data_if.en = 1;
    mem_if.addr_ok = 1;
    mem_if.data_ok = 1;
    #12;
    @(negedge clk);
    n_chk++;
    if ({mem_if.en, inst_if.addr_ok, data_if.addr_ok,
         inst_if.data_ok, data_if.data_ok, arb_err} !== 6'b0)
      $display("FAIL reset_outs got %b exp 000000",
               {mem_if.en, inst_if.addr_ok, data_if.addr_ok,
                inst_if.data_ok, data_if.data_ok, arb_err});
    else n_pass++;
    idle();
    cycle();
    resetn = 1;
    cycle();
    n_chk++;
    if (arb_err !== 1'b0)
      $display("FAIL reset_err got %b exp 0", arb_err);
    else n_pass++;
  endtask

  task automatic test_single_read();
    inst_if.en = 1;
    inst_if.addr = 32'hbfc00000;
    mem_if.addr_ok = 1;
    @(negedge clk);
    n_chk++;
    if ({mem_if.en, inst_if.addr_ok, data_if.addr_ok} !== 3'b110 ||
        mem_if.addr !== 32'hbfc00000 || mem_if.wr !== 1'b0)
      $display("FAIL single_req got en/ia/da=%b addr=%h exp 110 bfc00000",
               {mem_if.en, inst_if.addr_ok, data_if.addr_ok},
               mem_if.addr);
    else begin
      n_pass++;
      sb.push_back('{1'b0, 32'h3c08bfaf});
    end
    cycle();
    inst_if.en = 0;
    mem_if.addr_ok = 0;
    @(negedge clk);
    n_chk++;
    if (mem_if.en !== 1'b0 || inst_if.data_ok !== 1'b0)
      $display("FAIL single_idle got en=%b dok=%b exp 0 0",
               mem_if.en, inst_if.data_ok);
    else n_pass++;
    cycle();
    respond();
  endtask

  task automatic test_both_prio();
    inst_if.en = 1;
    inst_if.addr = 32'h00001000;
    data_if.en = 1;
    data_if.wr = 1;
    data_if.wen = 4'hf;
    data_if.addr = 32'h80002000;
    data_if.wdata = 32'h12345678;
    mem_if.addr_ok = 1;
    @(negedge clk);
    n_chk++;
    if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b01 ||
        mem_if.addr !== 32'h80002000 || mem_if.wr !== 1'b1 ||
        mem_if.wen !== 4'hf || mem_if.wdata !== 32'h12345678)
      $display("FAIL prio_data got ia/da=%b addr=%h wr=%b exp 01 80002000 1",
               {inst_if.addr_ok, data_if.addr_ok},
               mem_if.addr, mem_if.wr);
    else n_pass++;
    sb.push_back('{1'b1, 32'hd0d0d0d0});
    cycle();
    data_if.en = 0;
    @(negedge clk);
    n_chk++;
    if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b10 ||
        mem_if.addr !== 32'h00001000 || mem_if.wr !== 1'b0)
      $display("FAIL prio_inst got ia/da=%b addr=%h exp 10 00001000",
               {inst_if.addr_ok, data_if.addr_ok}, mem_if.addr);
    else n_pass++;
    sb.push_back('{1'b0, 32'h11112222});
    cycle();
    idle();
    cycle();
    respond();
    respond();
  endtask

  task automatic test_lock();
    inst_if.en = 1;
    inst_if.addr = 32'h00003000;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin
        data_if.en = 1;
        data_if.addr = 32'h80004000;
      end
      mem_if.addr_ok = (c == 3);
      @(negedge clk);
      n_chk++;
      if (mem_if.en !== 1'b1 || mem_if.addr !== 32'h00003000 ||
          data_if.addr_ok !== 1'b0 ||
          inst_if.addr_ok !== (c == 3))
        $display("FAIL lock_hold c=%0d got en=%b addr=%h ia=%b da=%b",
                 c, mem_if.en, mem_if.addr,
                 inst_if.addr_ok, data_if.addr_ok);
      else n_pass++;
      cycle();
    end
    sb.push_back('{1'b0, 32'h33330000});
    inst_if.en = 0;
    @(negedge clk);
    n_chk++;
    if (data_if.addr_ok !== 1'b1 || mem_if.addr !== 32'h80004000)
      $display("FAIL lock_after got da=%b addr=%h exp 1 80004000",
               data_if.addr_ok, mem_if.addr);
    else n_pass++;
    sb.push_back('{1'b1, 32'h44440000});
    cycle();
    idle();
    respond();
    respond();
  endtask

  task automatic test_full();
    exp_t e;
    inst_if.en = 1;
    mem_if.addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      inst_if.addr = 32'h00005000 + 32'(4 * i);
      @(negedge clk);
      n_chk++;
      if (inst_if.addr_ok !== 1'b1)
        $display("FAIL full_fill i=%0d got %b exp 1",
                 i, inst_if.addr_ok);
      else n_pass++;
      sb.push_back('{1'b0, 32'ha0000000 + 32'(i)});
      cycle();
    end
    inst_if.addr = 32'h00005010;
    @(negedge clk);
    n_chk++;
    if (mem_if.en !== 1'b0 || inst_if.addr_ok !== 1'b0)
      $display("FAIL full_block got en=%b ia=%b exp 0 0",
               mem_if.en, inst_if.addr_ok);
    else n_pass++;
    cycle();
    mem_if.data_ok = 1;
    mem_if.rdata = sb[0].rdata;
    @(negedge clk);
    n_chk++;
    if (mem_if.en !== 1'b0)
      $display("FAIL full_nobypass got en=%b exp 0", mem_if.en);
    else n_pass++;
    e = sb.pop_front();
    n_chk++;
    if (inst_if.data_ok !== 1'b1 || data_if.data_ok !== 1'b0 ||
        inst_if.rdata !== e.rdata)
      $display("FAIL full_pop got i=%b d=%b rdata=%h exp 1 0 %h",
               inst_if.data_ok, data_if.data_ok,
               inst_if.rdata, e.rdata);
    else n_pass++;
    cycle();
    mem_if.data_ok = 0;
    @(negedge clk);
    n_chk++;
    if (mem_if.en !== 1'b1 || inst_if.addr_ok !== 1'b1)
      $display("FAIL full_resume got en=%b ia=%b exp 1 1",
               mem_if.en, inst_if.addr_ok);
    else n_pass++;
    sb.push_back('{1'b0, 32'ha0000010});
    cycle();
    idle();
    for (int i = 0; i < 4; i++) respond();
  endtask

  task automatic test_err();
    mem_if.data_ok = 1;
    mem_if.rdata = 32'hbad0bad0;
    @(negedge clk);
    n_chk++;
    if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0)
      $display("FAIL err_route got i=%b d=%b exp 0 0",
               inst_if.data_ok, data_if.data_ok);
    else n_pass++;
    cycle();
    mem_if.data_ok = 0;
    cycle();
    cycle();
    n_chk++;
    if (arb_err !== 1'b1)
      $display("FAIL err_sticky got %b exp 1", arb_err);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    inst_if.en = 1;
    mem_if.addr_ok = 1;
    inst_if.addr = 32'h00006000;
    cycle();
    inst_if.addr = 32'h00006004;
    cycle();
    resetn = 0;
    @(negedge clk);
    n_chk++;
    if ({mem_if.en, inst_if.addr_ok, data_if.addr_ok,
         inst_if.data_ok, data_if.data_ok, arb_err} !== 6'b0)
      $display("FAIL midrst_outs got %b exp 000000",
               {mem_if.en, inst_if.addr_ok, data_if.addr_ok,
                inst_if.data_ok, data_if.data_ok, arb_err});
    else n_pass++;
    cycle();
    idle();
    resetn = 1;
    cycle();
    mem_if.data_ok = 1;
    mem_if.rdata = 32'h66660000;
    @(negedge clk);
    n_chk++;
    if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0)
      $display("FAIL midrst_late got i=%b d=%b exp 0 0",
               inst_if.data_ok, data_if.data_ok);
    else n_pass++;
    cycle();
    mem_if.data_ok = 0;
    n_chk++;
    if (arb_err !== 1'b1)
      $display("FAIL midrst_err got %b exp 1", arb_err);
    else n_pass++;
    inst_if.en = 1;
    inst_if.addr = 32'h00007000;
    mem_if.addr_ok = 1;
    @(negedge clk);
    n_chk++;
    if (inst_if.addr_ok !== 1'b1 || mem_if.addr !== 32'h00007000)
      $display("FAIL midrst_new got ia=%b addr=%h exp 1 00007000",
               inst_if.addr_ok, mem_if.addr);
    else n_pass++;
    sb.push_back('{1'b0, 32'h77770000});
    cycle();
    idle();
    cycle();
    respond();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    idle();
    resetn = 1;
    #2;
    test_reset();
    test_single_read();
    test_both_prio();
    test_lock();
    test_full();
    test_err();
    test_mid_reset();
    n_chk++;
    if (sb.size() != 0)
      $display("FAIL sb_drain got %0d left exp 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
